// File: rtl/ram_arbiter_if.sv
// Block-command bundle between the two requesters, the arbiter and the SDRAM controller.
// The arbiter uses the slave modport; requesters and the controller model sit on the master side.
interface ram_arbiter_if #(
  parameter int BlockWidth = 12
);
  logic                  img_req;
  logic [BlockWidth-1:0] img_block;
  logic                  img_gnt;
  logic                  img_done;
  logic                  sd_req;
  logic [BlockWidth-1:0] sd_block;
  logic                  sd_gnt;
  logic                  sd_done;
  logic                  ram_cmd_trigger;
  logic                  ram_cmd_ready;
  logic [BlockWidth-1:0] ram_cmd_block;
  logic                  ram_cmd_write;

  modport slave (
    input  img_req, img_block, img_done,
    input  sd_req, sd_block, sd_done,
    input  ram_cmd_ready,
    output img_gnt, sd_gnt,
    output ram_cmd_trigger, ram_cmd_block, ram_cmd_write
  );

  modport master (
    output img_req, img_block, img_done,
    output sd_req, sd_block, sd_done,
    output ram_cmd_ready,
    input  img_gnt, sd_gnt,
    input  ram_cmd_trigger, ram_cmd_block, ram_cmd_write
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester SDRAM block-command arbiter: img (write) has priority, sd (read) gets a slot after MaxImgConsec img grants.
// Optional ownership watchdog enabled by defining RAM_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | choose next owner from pending requests
// ISSUE | command presented, waiting for ram_cmd_ready
// OWNED | owner holds the RAM until its done pulse
module ram_arbiter #(
  parameter int BlockWidth    = 12,
  parameter int MaxImgConsec  = 4,
  parameter int TimeoutCycles = 65535
) (
  input  logic             clk,
  input  logic             rst_,
  ram_arbiter_if.slave     bus,
  output logic             err_timeout
);

  localparam int CW = $clog2(MaxImgConsec + 1);
  localparam logic [CW-1:0] CONSEC_MAX = CW'(MaxImgConsec);

  if (MaxImgConsec < 1) begin : g_bad_consec
    $error("ram_arbiter: MaxImgConsec must be >= 1");
  end
  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("ram_arbiter: TimeoutCycles must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    OWNED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_img_q, owner_img_d;
  logic                  img_gnt_q, img_gnt_d;
  logic                  sd_gnt_q, sd_gnt_d;
  logic                  trig_q, trig_d;
  logic [BlockWidth-1:0] block_q, block_d;
  logic                  write_q, write_d;
  logic [CW-1:0]         consec_q, consec_d;
  logic                  owner_done;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TimeoutCycles - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  // Done from the non-owner is never looked at.
  assign owner_done = owner_img_q ? bus.img_done : bus.sd_done;

  always_comb begin
    state_d     = state_q;
    owner_img_d = owner_img_q;
    img_gnt_d   = img_gnt_q;
    sd_gnt_d    = sd_gnt_q;
    trig_d      = trig_q;
    block_d     = block_q;
    write_d     = write_q;
    consec_d    = consec_q;
`ifdef RAM_ARB_TIMEOUT_EN
    tmo_d       = '0;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.img_req && !(bus.sd_req && consec_q == CONSEC_MAX)) begin
          owner_img_d = 1'b1;
          block_d     = bus.img_block;
          write_d     = 1'b1;
          trig_d      = 1'b1;
          state_d     = ISSUE;
          // img only wins with sd pending while below the limit, so +1 cannot overflow
          consec_d    = bus.sd_req ? consec_q + CW'(1) : '0;
        end else if (bus.sd_req) begin
          owner_img_d = 1'b0;
          block_d     = bus.sd_block;
          write_d     = 1'b0;
          trig_d      = 1'b1;
          state_d     = ISSUE;
          consec_d    = '0;
        end
      end
      ISSUE: begin
        if (bus.ram_cmd_ready) begin
          trig_d    = 1'b0;
          img_gnt_d = owner_img_q;
          sd_gnt_d  = !owner_img_q;
          state_d   = OWNED;
        end
`ifdef RAM_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          trig_d  = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      OWNED: begin
        if (owner_done) begin
          img_gnt_d = 1'b0;
          sd_gnt_d  = 1'b0;
          state_d   = IDLE;
        end
`ifdef RAM_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          img_gnt_d = 1'b0;
          sd_gnt_d  = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      default: begin
        img_gnt_d = 1'b0;
        sd_gnt_d  = 1'b0;
        trig_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      owner_img_q <= 1'b0;
      img_gnt_q   <= 1'b0;
      sd_gnt_q    <= 1'b0;
      trig_q      <= 1'b0;
      block_q     <= '0;
      write_q     <= 1'b0;
      consec_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_img_q <= owner_img_d;
      img_gnt_q   <= img_gnt_d;
      sd_gnt_q    <= sd_gnt_d;
      trig_q      <= trig_d;
      block_q     <= block_d;
      write_q     <= write_d;
      consec_q    <= consec_d;
    end
  end

`ifdef RAM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign bus.img_gnt         = img_gnt_q;
  assign bus.sd_gnt          = sd_gnt_q;
  assign bus.ram_cmd_trigger = trig_q;
  assign bus.ram_cmd_block   = block_q;
  assign bus.ram_cmd_write   = write_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single SDRAM block-command port between two requesters:
  - the image capture writer (img, write blocks);
  - the SD readout reader (sd, read blocks).
- Sits between the image-capture and SD-readout engines and the SDRAM controller's block interface, in the ice_img_clk16mhz-derived system clock domain.
- img has fixed priority because the sensor cannot be stalled. A consecutive-grant limit guarantees sd forward progress.
- Owns exactly one transaction at a time: issue, hold ownership, release on the owner's done pulse.

Parameters:
- BlockWidth, 12, width of RAM block index.
- MaxImgConsec, 4, max consecutive img grants while sd_req is pending before sd is forced (must be >= 1).
- TimeoutCycles, 65535, ownership watchdog limit in clk cycles (used only with RAM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst_  in  1  asynchronous active-low reset
- img_req  in  1  level request; held until img_gnt
- img_block  in  BlockWidth  block index; stable while img_req=1
- img_gnt  out  1  img owns RAM
- img_done  in  1  one-cycle pulse; img transfer complete
- sd_req  in  1  level request; held until sd_gnt
- sd_block  in  BlockWidth  block index; stable while sd_req=1
- sd_gnt  out  1  sd owns RAM
- sd_done  in  1  one-cycle pulse; sd transfer complete
- ram_cmd_trigger  out  1  command valid
- ram_cmd_ready  in  1  controller accepts command when trigger=1 and ready=1
- ram_cmd_block  out  BlockWidth  block index of issued command
- ram_cmd_write  out  1  1=write (img), 0=read (sd)
- err_timeout  out  1  sticky watchdog flag (tied 0 without RAM_ARB_TIMEOUT_EN)

Behaviour:
- Reset: async assert of rst_ forces:
  - state=IDLE;
  - img_gnt=0, sd_gnt=0, ram_cmd_trigger=0;
  - ram_cmd_block=0, ram_cmd_write=0;
  - consec counter=0, err_timeout=0.
- Reset mid-transaction drops the grant immediately. The controller must be reset in the same domain; no completion is owed.
- Deassertion of rst_ is synchronised by the codebase's reset synchroniser upstream.
- States: IDLE, ISSUE, OWNED. All outputs are registered.
- IDLE (sampled each cycle):
  - If img_req && !(sd_req && consec==MaxImgConsec): owner=img, latch img_block, ram_cmd_write=1.
  - Else if sd_req: owner=sd, latch sd_block, ram_cmd_write=0.
  - Any selection: ram_cmd_trigger=1 next cycle, go to ISSUE.
- ISSUE:
  - Hold trigger, block and write stable until ram_cmd_ready=1 in a cycle where trigger=1.
  - Next cycle: trigger=0, owner's gnt=1, go to OWNED.
  - Latency: request seen in IDLE at cycle N → trigger at N+1. Acceptance at M → gnt at M+1.
- OWNED:
  - Wait for the owner's done pulse. At done in cycle K: gnt=0 at K+1, state IDLE at K+1.
  - The earliest next trigger is K+2, a mandatory one-cycle gap.
  - done from the non-owner, or any done outside OWNED, is ignored.
- Request drops: a requester dropping req during ISSUE does not cancel the command; the transaction completes normally.
- Consec counter (width clog2(MaxImgConsec+1), saturating):
  - On an img grant decision while sd_req=1: counter +1.
  - On an img grant decision while sd_req=0: counter = 0.
  - On an sd grant decision: counter = 0.
- Simultaneous img_req and sd_req in IDLE: img wins unless counter==MaxImgConsec.
- Owner done and a new request in the same cycle: the new request is evaluated in the IDLE cycle that follows.
- img_gnt and sd_gnt are never both 1. gnt=1 implies trigger=0.

Optional Feature:
RAM_ARB_TIMEOUT_EN
- Defined:
  - A 16-bit (clog2(TimeoutCycles+1)) counter clears on entry to OWNED and increments each OWNED cycle.
  - Reaching TimeoutCycles without done drops gnt the next cycle and goes to IDLE.
  - err_timeout is set sticky until reset. The counter is also active in ISSUE, aborting with err_timeout if ready never comes.
- Undefined: no counter; OWNED and ISSUE wait indefinitely; err_timeout is constant 0.

Test Plan:
- Reset then img_req=1 with img_block=0x123, ready=1 → trigger at +1 with block 0x123 and write=1; img_gnt at +2. img_done → gnt low next cycle.
- sd_req=1 with sd_block=0x7FF and ram_cmd_ready held low 5 cycles → trigger held 5 cycles with stable block 0x7FF and write=0; sd_gnt the cycle after ready=1.
- img_req and sd_req both held continuously, MaxImgConsec=4 → grant order img,img,img,img,sd,img,img,img,img,sd; one-cycle gap after each done.
- sd_done pulsed while img owns RAM → ignored; img_gnt remains 1 until img_done.
- rst_ asserted asynchronously mid-OWNED (between clock edges) → img_gnt and sd_gnt 0 immediately; IDLE after release; err_timeout=0.
- RAM_ARB_TIMEOUT_EN with TimeoutCycles=10 and no done after grant → gnt drops after 10 OWNED cycles and err_timeout=1 stays high. Without the macro → gnt held 1000 cycles and err_timeout=0.
